adf4351_spi_rx: RTL and testbench
=================================

// Module: adf4351_spi_rx
// PURPOSE
//  Receiver end of the ADF4351 3-wire serial load interface (clock/data/latch-enable).
//  Oversamples the lines with CLK and assembles MSB-first 32-bit words.
//  Decodes control bits [2:0] into a shadow register file R0..R5.
//  Flags malformed frames and detects a complete R5->R0 load sequence.
//  Sits beside each PLL load port as a loopback checker and read-back source.
// PARAMETERS
//  SYNC_STAGES  2   flip-flop stages on each serial input (>=2)
//  CNT_W        16  width of the WR_CNT accepted-word counter
// PORTS
//  CLK         in   1      system clock; sole clock of the block
//  RST         in   1      reset, asynchronous, active-low
//  SCLK        in   1      serial data clock (async to CLK)
//  SDATA       in   1      serial data, MSB first, sampled on SCLK rise
//  SLE         in   1      latch enable; rising edge ends a frame
//  WORD_VALID  out  1      1-cycle pulse: a word was accepted
//  WORD_ADDR   out  3      register address of accepted word (= word[2:0])
//  WORD_DATA   out  32     accepted word, held until next accept
//  FRAME_ERR   out  1      1-cycle pulse: frame rejected
//  SEQ_DONE    out  1      1-cycle pulse: R5,R4,R3,R2,R1,R0 received in order
//  WR_CNT      out  CNT_W  accepted-word count, wraps at 2^CNT_W
//  RD_ADDR     in   3      shadow read address
//  RD_DATA     out  32     shadow[RD_ADDR], registered
// BEHAVIOUR
//  Reset (RST=0, async): shadow R0..R5=0, all outputs 0, shift reg=0, bit count=0, seq FSM=EXP5.
//  - Sync chain resets to 0.
//  Input path: SCLK/SDATA/SLE each pass SYNC_STAGES FFs; edges detected on synced copies.
//  - Requirement on the source: SCLK high and low >= SYNC_STAGES+1 CLK cycles.
//  - SDATA stable across that window.
//  Shift: on synced SCLK rise with synced SLE low:
//  - shift <= {shift[30:0],SDATA}.
//  - bitcnt++ saturating at 63.
//  - SCLK rises while SLE high are ignored.
//  Latch: on synced SLE rise, the frame is accepted iff bitcnt==32 and shift[2:0]<=5.
//  - Same-cycle SCLK rise and SLE rise: the shift is applied first, then the latch check.
//  Accept, next cycle:
//  - shadow[shift[2:0]] <= shift.
//  - WORD_DATA <= shift, WORD_ADDR <= shift[2:0].
//  - WORD_VALID=1 for 1 cycle, WR_CNT++.
//  Reject (bitcnt!=32 or addr 6/7):
//  - FRAME_ERR=1 for 1 cycle.
//  - Shadow, WORD_* and WR_CNT unchanged.
//  Either case: bitcnt cleared on the SLE rise.
//  - Latency: SLE pin rise to WORD_VALID = SYNC_STAGES+2 CLK.
//  Sequence FSM states: EXP5,EXP4,EXP3,EXP2,EXP1,EXP0. Evaluated on accept only.
//  - Accepted addr == expected: advance. From EXP0 -> SEQ_DONE pulse (same cycle as WORD_VALID), go EXP5.
//  - Accepted addr != expected: addr==5 -> EXP4; else -> EXP5.
//  - FRAME_ERR: FSM -> EXP5.
//  Read: RD_DATA <= shadow[RD_ADDR] every cycle (1-cycle latency); addr 6/7 -> 0.
//  - A same-cycle shadow write is visible on RD_DATA one cycle later (new value, no bypass).
//  Reset mid-frame: partial bits discarded; the next full frame decodes normally.
// TESTING
//  1 Frame 0x00400005 (32 clk, SLE pulse) -> WORD_VALID once, ADDR=5, DATA=0x00400005, RD_ADDR=5 reads it.
//  2 Frames R5 0x00400005, R4 0x00AC803C, R3 0x000004B3, R2 0x00004E42, R1 0x0800E1A9, R0 0x00500000
//    -> six WORD_VALID, SEQ_DONE exactly once with the R0 word, WR_CNT=6.
//  3 31-bit frame of 0x00500000>>1, then 33-bit frame -> FRAME_ERR twice, shadow R0 unchanged, WR_CNT unchanged.
//  4 Frame 0x00000006 (addr 6) -> FRAME_ERR, no WORD_VALID, RD_ADDR=6 reads 0.
//  5 R5,R4,R2,R1,R0 then R5..R0 -> no SEQ_DONE for the first run, one SEQ_DONE on the second R0.
//  6 Assert RST after 16 bits of a frame, release, send 0x0800E1A9 -> accepted, ADDR=1, no FRAME_ERR.

Source files
------------

// File: rtl/adf4351_spi_rx.sv
// ADF4351 3-wire load port receiver: oversampled deserializer,
// R0..R5 shadow file, frame checking and R5->R0 sequence detection.
module adf4351_spi_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SCLK,
  input  logic             SDATA,
  input  logic             SLE,
  output logic             WORD_VALID,
  output logic [2:0]       WORD_ADDR,
  output logic [31:0]      WORD_DATA,
  output logic             FRAME_ERR,
  output logic             SEQ_DONE,
  output logic [CNT_W-1:0] WR_CNT,
  input  logic [2:0]       RD_ADDR,
  output logic [31:0]      RD_DATA
);

  typedef enum logic [2:0] {
    EXP0 = 3'd0,
    EXP1 = 3'd1,
    EXP2 = 3'd2,
    EXP3 = 3'd3,
    EXP4 = 3'd4,
    EXP5 = 3'd5
  } seq_t;

  logic [SYNC_STAGES-1:0] r_sclk_s;
  logic [SYNC_STAGES-1:0] r_sdata_s;
  logic [SYNC_STAGES-1:0] r_sle_s;
  logic                   r_sclk_q;
  logic                   r_sle_q;

  logic [31:0] r_shift;
  logic [5:0]  r_cnt;
  logic        r_acc_p;
  logic        r_rej_p;
  logic [31:0] r_word_p;

  logic [31:0] r_shadow [0:5];
  seq_t        r_state;
  seq_t        w_next;

  logic        w_sclk;
  logic        w_sdata;
  logic        w_sle;
  logic        w_sclk_rise;
  logic        w_sle_rise;
  logic        w_shift_en;
  logic [31:0] w_shift_nx;
  logic [5:0]  w_cnt_nx;
  logic        w_ok;
  logic [2:0]  w_addr_p;

  assign w_sclk  = r_sclk_s[SYNC_STAGES-1];
  assign w_sdata = r_sdata_s[SYNC_STAGES-1];
  assign w_sle   = r_sle_s[SYNC_STAGES-1];

  assign w_sclk_rise = w_sclk & ~r_sclk_q;
  assign w_sle_rise  = w_sle & ~r_sle_q;
  // Gate on the previous SLE level so a coincident SCLK rise still shifts
  assign w_shift_en  = w_sclk_rise & ~r_sle_q;

  assign w_shift_nx = w_shift_en ? {r_shift[30:0], w_sdata} : r_shift;
  assign w_cnt_nx   = (w_shift_en && r_cnt != 6'd63) ? r_cnt + 6'd1 : r_cnt;
  assign w_ok       = (w_cnt_nx == 6'd32) && (w_shift_nx[2:0] <= 3'd5);
  assign w_addr_p   = r_word_p[2:0];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sclk_s  <= '0;
      r_sdata_s <= '0;
      r_sle_s   <= '0;
      r_sclk_q  <= 1'b0;
      r_sle_q   <= 1'b0;
    end else begin
      r_sclk_s  <= {r_sclk_s[SYNC_STAGES-2:0], SCLK};
      r_sdata_s <= {r_sdata_s[SYNC_STAGES-2:0], SDATA};
      r_sle_s   <= {r_sle_s[SYNC_STAGES-2:0], SLE};
      r_sclk_q  <= w_sclk;
      r_sle_q   <= w_sle;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_acc_p  <= 1'b0;
      r_rej_p  <= 1'b0;
      r_word_p <= '0;
    end else begin
      r_shift <= w_shift_nx;
      r_cnt   <= w_sle_rise ? 6'd0 : w_cnt_nx;
      r_acc_p <= w_sle_rise & w_ok;
      r_rej_p <= w_sle_rise & ~w_ok;
      if (w_sle_rise && w_ok)
        r_word_p <= w_shift_nx;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      WORD_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
      WORD_ADDR  <= '0;
      WORD_DATA  <= '0;
      WR_CNT     <= '0;
      for (int i = 0; i < 6; i++)
        r_shadow[i] <= '0;
    end else begin
      WORD_VALID <= r_acc_p;
      FRAME_ERR  <= r_rej_p;
      if (r_acc_p) begin
        r_shadow[w_addr_p] <= r_word_p;
        WORD_ADDR          <= w_addr_p;
        WORD_DATA          <= r_word_p;
        WR_CNT             <= WR_CNT + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next = EXP5;
    unique case (r_state)
      EXP5:    w_next = EXP4;
      EXP4:    w_next = EXP3;
      EXP3:    w_next = EXP2;
      EXP2:    w_next = EXP1;
      EXP1:    w_next = EXP0;
      default: w_next = EXP5;
    endcase
  end

  // Enum encoding equals the address each state waits for
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= EXP5;
      SEQ_DONE <= 1'b0;
    end else begin
      SEQ_DONE <= 1'b0;
      if (r_acc_p) begin
        if (w_addr_p == r_state) begin
          r_state  <= w_next;
          SEQ_DONE <= (r_state == EXP0);
        end else if (w_addr_p == 3'd5) begin
          r_state <= EXP4;
        end else begin
          r_state <= EXP5;
        end
      end else if (r_rej_p) begin
        r_state <= EXP5;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      RD_DATA <= '0;
    else if (RD_ADDR <= 3'd5)
      RD_DATA <= r_shadow[RD_ADDR];
    else
      RD_DATA <= '0;
  end

endmodule

// File: tb/tb_adf4351_spi_rx.sv
// Directed bench for adf4351_spi_rx: frames, sequencing,
// malformed frames, read-back and mid-frame reset.
module tb_adf4351_spi_rx;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        SCLK = 1'b0;
  logic        SDATA = 1'b0;
  logic        SLE = 1'b0;
  logic        WORD_VALID;
  logic [2:0]  WORD_ADDR;
  logic [31:0] WORD_DATA;
  logic        FRAME_ERR;
  logic        SEQ_DONE;
  logic [15:0] WR_CNT;
  logic [2:0]  RD_ADDR = 3'd0;
  logic [31:0] RD_DATA;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int sle_cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_seq = 0;
  int valid_cyc = 0;
  int seq_addr = -1;
  int seq_on_valid = 0;
  int v0, e0, s0;

  adf4351_spi_rx #(.SYNC_STAGES(2), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .SCLK(SCLK), .SDATA(SDATA), .SLE(SLE),
    .WORD_VALID(WORD_VALID), .WORD_ADDR(WORD_ADDR),
    .WORD_DATA(WORD_DATA), .FRAME_ERR(FRAME_ERR),
    .SEQ_DONE(SEQ_DONE), .WR_CNT(WR_CNT),
    .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (WORD_VALID) begin
      n_valid   = n_valid + 1;
      valid_cyc = cyc;
    end
    if (FRAME_ERR) n_err = n_err + 1;
    if (SEQ_DONE) begin
      n_seq        = n_seq + 1;
      seq_addr     = int'(WORD_ADDR);
      seq_on_valid = int'(WORD_VALID);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic shift_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      SDATA = v[i];
      tick(4);
      SCLK = 1'b1;
      tick(4);
      SCLK = 1'b0;
    end
  endtask

  task automatic latch();
    tick(4);
    SLE = 1'b1;
    sle_cyc = cyc;
    tick(4);
    SLE = 1'b0;
    tick(8);
  endtask

  task automatic send(input logic [63:0] v, input int n);
    shift_bits(v, n);
    latch();
  endtask

  task automatic pulse_rst();
    RST = 1'b0;
    tick(3);
    RST = 1'b1;
    tick(2);
  endtask

  initial begin
    tick(3);
    RST = 1'b1;
    tick(2);
    chk("rst_valid", 32'(WORD_VALID), 32'd0);
    chk("rst_err", 32'(FRAME_ERR), 32'd0);
    chk("rst_seq", 32'(SEQ_DONE), 32'd0);
    chk("rst_data", WORD_DATA, 32'd0);
    chk("rst_cnt", 32'(WR_CNT), 32'd0);
    chk("rst_rd", RD_DATA, 32'd0);

    // 1: single R5 word
    send(64'h00400005, 32);
    chk("t1_nvalid", n_valid, 1);
    chk("t1_nerr", n_err, 0);
    chk("t1_addr", 32'(WORD_ADDR), 32'd5);
    chk("t1_data", WORD_DATA, 32'h00400005);
    chk("t1_latency", valid_cyc - sle_cyc, 4);
    chk("t1_cnt", 32'(WR_CNT), 32'd1);
    RD_ADDR = 3'd5;
    tick(2);
    chk("t1_rd5", RD_DATA, 32'h00400005);

    // 2: full R5..R0 sequence
    pulse_rst();
    chk("t2_rst_cnt", 32'(WR_CNT), 32'd0);
    chk("t2_rst_rd5", RD_DATA, 32'd0);
    v0 = n_valid; s0 = n_seq;
    send(64'h00400005, 32);
    send(64'h00AC803C, 32);
    send(64'h000004B3, 32);
    send(64'h00004E42, 32);
    send(64'h0800E1A9, 32);
    chk("t2_seq_pre", n_seq - s0, 0);
    send(64'h00500000, 32);
    chk("t2_nvalid", n_valid - v0, 6);
    chk("t2_nseq", n_seq - s0, 1);
    chk("t2_seq_addr", seq_addr, 0);
    chk("t2_seq_with_valid", seq_on_valid, 1);
    chk("t2_cnt", 32'(WR_CNT), 32'd6);
    RD_ADDR = 3'd4;
    tick(2);
    chk("t2_rd4", RD_DATA, 32'h00AC803C);
    RD_ADDR = 3'd0;
    tick(2);
    chk("t2_rd0", RD_DATA, 32'h00500000);

    // 3: short and long frames
    v0 = n_valid; e0 = n_err;
    send(64'h00280000, 31);
    chk("t3_err31", n_err - e0, 1);
    send({31'd0, 1'b1, 32'h00500000}, 33);
    chk("t3_err", n_err - e0, 2);
    chk("t3_nvalid", n_valid - v0, 0);
    chk("t3_cnt", 32'(WR_CNT), 32'd6);
    tick(2);
    chk("t3_rd0", RD_DATA, 32'h00500000);

    // 4: bad address
    v0 = n_valid; e0 = n_err;
    send(64'h00000006, 32);
    chk("t4_err", n_err - e0, 1);
    chk("t4_nvalid", n_valid - v0, 0);
    chk("t4_cnt", 32'(WR_CNT), 32'd6);
    RD_ADDR = 3'd6;
    tick(2);
    chk("t4_rd6", RD_DATA, 32'd0);
    RD_ADDR = 3'd7;
    tick(2);
    chk("t4_rd7", RD_DATA, 32'd0);

    // 5: broken run then full run
    v0 = n_valid; s0 = n_seq;
    send(64'h00400005, 32);
    send(64'h00AC803C, 32);
    send(64'h00004E42, 32);
    send(64'h0800E1A9, 32);
    send(64'h00500000, 32);
    chk("t5_seq_first", n_seq - s0, 0);
    send(64'h00400005, 32);
    send(64'h00AC803C, 32);
    send(64'h000004B3, 32);
    send(64'h00004E42, 32);
    send(64'h0800E1A9, 32);
    chk("t5_seq_mid", n_seq - s0, 0);
    send(64'h00500000, 32);
    chk("t5_seq_second", n_seq - s0, 1);
    chk("t5_nvalid", n_valid - v0, 11);
    chk("t5_cnt", 32'(WR_CNT), 32'd17);

    // 6: reset after 16 bits, then a clean frame
    shift_bits(64'h0800, 16);
    pulse_rst();
    v0 = n_valid; e0 = n_err;
    send(64'h0800E1A9, 32);
    chk("t6_nvalid", n_valid - v0, 1);
    chk("t6_err", n_err - e0, 0);
    chk("t6_addr", 32'(WORD_ADDR), 32'd1);
    chk("t6_data", WORD_DATA, 32'h0800E1A9);
    chk("t6_cnt", 32'(WR_CNT), 32'd1);
    RD_ADDR = 3'd1;
    tick(2);
    chk("t6_rd1", RD_DATA, 32'h0800E1A9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
